// File: rtl/fft_pkg.sv
// Shared constants, complex/twiddle types and saturation helpers for the R2SDF FFT stage.
// FFT_ROUND_EN selects round-half-up; otherwise shifts truncate toward -inf.
package fft_pkg;

  localparam int N       = 16;
  localparam int DW      = 17;
  localparam int TW      = 16;
  localparam int TW_FRAC = 14;
  localparam int HALF    = N / 2;
  localparam int CW      = $clog2(N);
  localparam int AW      = DW + TW + 1;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW-1:0] wr;
    logic signed [TW-1:0] wi;
  } twiddle_t;

  typedef enum logic {
    PHASE_FILL = 1'b0,
    PHASE_BFLY = 1'b1
  } phase_t;

`ifdef FFT_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam logic signed [AW-1:0] HALF_RND = ROUND_EN ? AW'(1) : '0;
  localparam logic signed [AW-1:0] MUL_RND  = ROUND_EN ? (AW'(1) <<< (TW_FRAC - 1)) : '0;

  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 << (DW - 1)));

  // W16^n = e^(-j2*pi*n/16) in Q1.14
  localparam twiddle_t TWIDDLE_ROM [0:HALF-1] = '{
    '{ 16'sd16384,  16'sd0     },
    '{ 16'sd15137, -16'sd6270  },
    '{ 16'sd11585, -16'sd11585 },
    '{ 16'sd6270,  -16'sd15137 },
    '{ 16'sd0,     -16'sd16384 },
    '{-16'sd6270,  -16'sd15137 },
    '{-16'sd11585, -16'sd11585 },
    '{-16'sd15137, -16'sd6270  }
  };

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[DW-1:0];
    if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] half_sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] r;
    r = (v + HALF_RND) >>> 1;
    return sat_dw(r);
  endfunction

endpackage

// File: rtl/cplx_twiddle_mul.sv
// Combinational complex multiply by a Q1.14 twiddle, rescale and saturate to DW bits.
// FFT_ROUND_EN (via fft_pkg) adds half an LSB before the >>14.
module cplx_twiddle_mul
  import fft_pkg::*;
(
  input  cplx_t    a,
  input  twiddle_t w,
  output cplx_t    y
);

  logic signed [AW-1:0] re_acc;
  logic signed [AW-1:0] im_acc;
  logic signed [AW-1:0] re_sh;
  logic signed [AW-1:0] im_sh;

  always_comb begin
    re_acc = AW'($signed(a.re)) * AW'($signed(w.wr)) - AW'($signed(a.im)) * AW'($signed(w.wi));
    im_acc = AW'($signed(a.re)) * AW'($signed(w.wi)) + AW'($signed(a.im)) * AW'($signed(w.wr));
    re_sh  = (re_acc + MUL_RND) >>> TW_FRAC;
    im_sh  = (im_acc + MUL_RND) >>> TW_FRAC;
    y.re   = sat_dw(re_sh);
    y.im   = sat_dw(im_sh);
  end

endmodule

// File: rtl/fft16_sdf_stage.sv
// First radix-2 SDF stage of a 16-point DIF FFT: halved butterfly, 8-deep feedback line, twiddle.
// FFT_ROUND_EN (via fft_pkg) switches all rescaling from truncation to round-half-up.
module fft16_sdf_stage
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2*DW-1:0] data_in,
  output logic [2*DW-1:0] data_out
);

  logic [CW-1:0] cnt;
  cplx_t         dline [0:HALF-1];
  cplx_t         x;
  cplx_t         head;
  cplx_t         sum_half;
  cplx_t         diff_half;
  cplx_t         twid_out;
  twiddle_t      w;
  phase_t        phase;

  assign x     = data_in;
  assign head  = dline[HALF-1];
  assign phase = phase_t'(cnt[CW-1]);
  assign w     = TWIDDLE_ROM[cnt[CW-2:0]];

  always_comb begin
    sum_half.re  = half_sat(AW'($signed(head.re)) + AW'($signed(x.re)));
    sum_half.im  = half_sat(AW'($signed(head.im)) + AW'($signed(x.im)));
    diff_half.re = half_sat(AW'($signed(head.re)) - AW'($signed(x.re)));
    diff_half.im = half_sat(AW'($signed(head.im)) - AW'($signed(x.im)));
  end

  // In the fill phase the line head is the previous frame's difference for index cnt
  cplx_twiddle_mul u_twiddle (
    .a (head),
    .w (w),
    .y (twid_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      data_out <= '0;
      for (int i = 0; i < HALF; i++) dline[i] <= '0;
    end else begin
      cnt      <= cnt + CW'(1);
      dline[0] <= (phase == PHASE_BFLY) ? diff_half : x;
      for (int i = 1; i < HALF; i++) dline[i] <= dline[i-1];
      data_out <= (phase == PHASE_BFLY) ? sum_half : twid_out;
    end
  end

endmodule

// File: tb/tb_fft16_sdf_stage.sv
// Directed bench for fft16_sdf_stage; expectations adapt to FFT_ROUND_EN where rounding matters.
module tb_fft16_sdf_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [33:0] data_in;
  logic [33:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  int xr [16];
  int xi [16];
  int er [16];
  int ei [16];

`ifdef FFT_ROUND_EN
  localparam int SAT_A0 = 0;
  localparam int B1_IM  = 462;
  localparam int B3_RE  = 924;
  localparam int B3_IM  = 383;
`else
  localparam int SAT_A0 = -1;
  localparam int B1_IM  = 461;
  localparam int B3_RE  = 923;
  localparam int B3_IM  = 382;
`endif

  always #5 clk = ~clk;

  fft16_sdf_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .data_out (data_out)
  );

  function automatic logic [33:0] pack(input int re, input int im);
    logic [16:0] r;
    logic [16:0] i;
    r = re[16:0];
    i = im[16:0];
    return {r, i};
  endfunction

  task automatic applyStimulus(input logic rst_v, input int re, input int im);
    rst_n   = rst_v;
    data_in = pack(re, im);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int re, input int im);
    logic [33:0] exp_w;
    exp_w = pack(re, im);
    n_checks++;
    assert (data_out === exp_w) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed re=%0d im=%0d expected re=%0d im=%0d",
             tag, $signed(data_out[33:17]), $signed(data_out[16:0]), re, im);
    end
  endtask

  task automatic clearFrame();
    for (int k = 0; k < 16; k++) begin
      xr[k] = 0;
      xi[k] = 0;
      er[k] = 0;
      ei[k] = 0;
    end
  endtask

  // Slots 0..7 expect the previous frame's b[n], slots 8..15 this frame's a[n]
  task automatic runFrame(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      applyStimulus(1'b1, xr[c], xi[c]);
      checkOutput($sformatf("%s[%0d]", name, c), er[c], ei[c]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    data_in = '0;

    for (int k = 0; k < 3; k++) begin
      rst_n   = 1'b0;
      data_in = {2'b10, $urandom};
      @(posedge clk);
      #1;
      checkOutput($sformatf("reset[%0d]", k), 0, 0);
    end

    clearFrame();
    xr[0] = 1000;
    er[8] = 500;
    runFrame("impulse", 16);

    clearFrame();
    for (int k = 0; k < 16; k++) xr[k] = 800;
    er[0] = 500;
    for (int k = 8; k < 16; k++) er[k] = 800;
    runFrame("dc", 16);

    clearFrame();
    xi[1] = 1000;
    ei[9] = 500;
    runFrame("twiddle", 16);

    clearFrame();
    xr[8] = 1000;
    er[1] = 191;
    ei[1] = B1_IM;
    er[8] = 500;
    runFrame("signdiff", 16);

    clearFrame();
    xr[0] = 65535;
    xr[8] = -65536;
    er[0] = -500;
    er[8] = SAT_A0;
    runFrame("saturate", 16);

    clearFrame();
    xi[3]  = 2000;
    er[0]  = 65535;
    ei[11] = 1000;
    runFrame("w3", 16);

    clearFrame();
    for (int k = 0; k < 16; k++) begin
      xr[k] = 300;
      xi[k] = -200;
    end
    er[3] = B3_RE;
    ei[3] = B3_IM;
    runFrame("partial", 5);

    applyStimulus(1'b0, 300, -200);
    checkOutput("rst_mid", 0, 0);

    clearFrame();
    xr[0] = 1000;
    er[8] = 500;
    runFrame("impulse_rerun", 16);

    clearFrame();
    er[0] = 500;
    runFrame("back2back", 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
